// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. A hit answers one cycle after the request.
// A miss refills the whole line from mem_ctrl, one word per request, and then answers.
module icache #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ic_read,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_ans,
  output logic        ic_done,
  input  logic        ic_flush,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_ans,
  input  logic        mem_done
);

  localparam int TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                  state, state_nx;
  logic [LINES-1:0]        valid;
  logic [TAG_BITS-1:0]     tag_arr  [0:LINES-1];
  logic [31:0]             data_arr [0:LINES*WORDS-1];

  logic [TAG_BITS-1:0]     l_tag;
  logic [INDEX_BITS-1:0]   l_idx;
  logic [OFFSET_BITS-1:0]  l_off;
  logic [OFFSET_BITS-1:0]  cnt;
  logic [31:0]             saved;
  logic                    flush_pend;

  logic [TAG_BITS-1:0]     a_tag;
  logic [INDEX_BITS-1:0]   a_idx;
  logic [OFFSET_BITS-1:0]  a_off;
  logic                    hit, last, miss_take, fill_we, fill_last;
  logic [31:0]             rd_word;
  logic                    ic_done_nx, mem_read_nx;
  logic [31:0]             ic_ans_nx, mem_addr_nx;
  logic                    unused_addr_bits;

  assign a_tag            = ic_addr[31:32-TAG_BITS];
  assign a_idx            = ic_addr[OFFSET_BITS+2 +: INDEX_BITS];
  assign a_off            = ic_addr[2 +: OFFSET_BITS];
  assign unused_addr_bits = ^ic_addr[1:0];

  assign hit       = valid[a_idx] && (tag_arr[a_idx] == a_tag);
  assign rd_word   = data_arr[{a_idx, a_off}];
  assign last      = &cnt;
  assign miss_take = (state == IDLE) && ic_read && !hit;
  assign fill_we   = (state == WAIT) && mem_done;
  assign fill_last = fill_we && last;

  // State, control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ic_done    <= 1'b0;
      ic_ans     <= '0;
      mem_read   <= 1'b0;
      mem_addr   <= '0;
      cnt        <= '0;
      valid      <= '0;
      flush_pend <= 1'b0;
    end else if (rdy) begin
      state    <= state_nx;
      ic_done  <= ic_done_nx;
      ic_ans   <= ic_ans_nx;
      mem_read <= mem_read_nx;
      mem_addr <= mem_addr_nx;
      if (miss_take)
        cnt <= '0;
      else if (fill_we && !last)
        cnt <= cnt + {{(OFFSET_BITS-1){1'b0}}, 1'b1};
      // A flush wins over a completing refill; a flush seen mid-refill keeps that line invalid.
      if (ic_flush)
        valid <= '0;
      else if (fill_last && !flush_pend)
        valid[l_idx] <= 1'b1;
      if (state == IDLE)
        flush_pend <= 1'b0;
      else if (ic_flush && (state == REQ || state == WAIT))
        flush_pend <= 1'b1;
    end
  end

  // Tag/data arrays and miss bookkeeping carry no reset
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (miss_take) begin
        l_tag <= a_tag;
        l_idx <= a_idx;
        l_off <= a_off;
      end
      if (fill_we)
        data_arr[{l_idx, cnt}] <= mem_ans;
      if (fill_we && (cnt == l_off))
        saved <= mem_ans;
      if (fill_last)
        tag_arr[l_idx] <= l_tag;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (ic_read) state_nx = hit ? RESP : REQ;
      REQ:  state_nx = WAIT;
      WAIT: if (mem_done) state_nx = last ? RESP : REQ;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ic_done_nx  = ic_done;
    ic_ans_nx   = ic_ans;
    mem_read_nx = mem_read;
    mem_addr_nx = mem_addr;
    case (state)
      IDLE: begin
        ic_done_nx = 1'b0;
        if (ic_read && hit) begin
          ic_ans_nx  = rd_word;
          ic_done_nx = 1'b1;
        end
      end
      REQ: begin
        mem_read_nx = 1'b1;
        mem_addr_nx = {l_tag, l_idx, cnt, 2'b00};
      end
      WAIT: begin
        if (mem_done) begin
          mem_read_nx = 1'b0;
          if (last) begin
            // The requested word may be arriving right now as the last word of the line.
            ic_ans_nx  = (cnt == l_off) ? mem_ans : saved;
            ic_done_nx = 1'b1;
          end
        end
      end
      RESP: ic_done_nx = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a vector table of fetches plus hand-written flush,
// freeze and reset sequences, with a behavioural mem_ctrl responder.
module tb_icache;

  logic        clk, rst, rdy, ic_read, ic_done, ic_flush, mem_read, mem_done;
  logic [31:0] ic_addr, ic_ans, mem_addr, mem_ans;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_base = 32'h0;
  int          mem_lat  = 1;
  bit          mem_en   = 1'b1;
  int          read_cnt = 0;
  int          rise_cnt = 0;
  logic [31:0] log_a [0:15];
  logic        mr_prev  = 1'b0;

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_ans(ic_ans), .ic_done(ic_done),
    .ic_flush(ic_flush),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_ans(mem_ans), .mem_done(mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mem_ctrl model: answers base + word number, one pulse per request
  initial begin
    mem_done = 1'b0;
    mem_ans  = '0;
    forever begin
      @(negedge clk);
      if (mem_read && mem_en) begin
        if (read_cnt < 16) log_a[read_cnt] = mem_addr;
        read_cnt++;
        repeat (mem_lat) @(negedge clk);
        mem_ans  = mem_base + {28'h0, mem_addr[3:2]};
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mem_read && !mr_prev) rise_cnt++;
    mr_prev = mem_read;
  end

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] base,
                         input logic [31:0] exp_ans, input int exp_reads,
                         input bit flush, input string nm);
    int cyc;
    bit got;
    @(negedge clk);
    mem_base = base;
    read_cnt = 0;
    rise_cnt = 0;
    ic_addr  = a;
    ic_read  = 1'b1;
    ic_flush = flush;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      ic_flush = 1'b0;
      cyc++;
      if (ic_done) got = 1'b1;
    end
    ic_read = 1'b0;
    chk(32'(got), 32'd1, {nm, " done seen"});
    if (got) begin
      chk(ic_ans, exp_ans, {nm, " ic_ans"});
      chk(32'(read_cnt), 32'(exp_reads), {nm, " mem reads"});
      chk(32'(rise_cnt), 32'(exp_reads), {nm, " mem_read low between words"});
      if (exp_reads == 0)
        chk(32'(cyc), 32'd1, {nm, " hit latency"});
      for (int i = 0; i < exp_reads && i < 16; i++)
        chk(log_a[i], {a[31:4], 4'h0} + 32'(4 * i), {nm, $sformatf(" mem_addr word %0d", i)});
    end
    @(negedge clk);
    chk(32'(ic_done), 32'd0, {nm, " ic_done one-cycle pulse"});
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
    logic [31:0] ans;
    int          reads;
    bit          flush;
    string       name;
  } vec_t;

  vec_t vecs [0:11];

  initial begin
    vecs[0]  = '{32'h0000_1004, 32'hA0, 32'hA1, 4, 1'b0, "cold miss 1004"};
    vecs[1]  = '{32'h0000_100C, 32'hA0, 32'hA3, 0, 1'b0, "hit 100C"};
    vecs[2]  = '{32'h0000_1000, 32'hA0, 32'hA0, 0, 1'b0, "hit 1000"};
    vecs[3]  = '{32'h0000_1404, 32'hB0, 32'hB1, 4, 1'b0, "conflict 1404"};
    vecs[4]  = '{32'h0000_1004, 32'hA0, 32'hA1, 4, 1'b0, "evicted 1004"};
    vecs[5]  = '{32'h0000_2018, 32'hC0, 32'hC2, 4, 1'b0, "miss 2018"};
    vecs[6]  = '{32'h0000_1008, 32'hA0, 32'hA2, 0, 1'b0, "hit 1008"};
    vecs[7]  = '{32'h0000_2014, 32'hC0, 32'hC1, 0, 1'b0, "hit 2014"};
    vecs[8]  = '{32'h0000_600C, 32'hF0, 32'hF3, 4, 1'b0, "miss last word 600C"};
    vecs[9]  = '{32'h0000_6000, 32'hF0, 32'hF0, 0, 1'b0, "hit 6000"};
    vecs[10] = '{32'h0000_2010, 32'hC0, 32'hC0, 0, 1'b1, "hit with flush 2010"};
    vecs[11] = '{32'h0000_2010, 32'hC0, 32'hC0, 4, 1'b0, "after flush 2010"};

    rst = 1'b0; rdy = 1'b1; ic_read = 1'b0; ic_addr = '0; ic_flush = 1'b0;
    repeat (3) @(negedge clk);
    chk(32'(ic_done), 32'd0, "reset ic_done");
    chk(32'(mem_read), 32'd0, "reset mem_read");
    chk(mem_addr, 32'h0, "reset mem_addr");
    chk(ic_ans, 32'h0, "reset ic_ans");
    rst = 1'b1;

    for (int i = 0; i < 12; i++)
      do_read(vecs[i].addr, vecs[i].base, vecs[i].ans, vecs[i].reads, vecs[i].flush, vecs[i].name);

    // Flush while waiting on word 2: request still completes, line stays invalid
    mem_lat = 3;
    fork
      do_read(32'h0000_3028, 32'hD0, 32'hD2, 4, 1'b0, "flush mid-refill 3028");
      begin
        int k = 0;
        @(negedge clk);
        @(negedge clk);
        while (read_cnt < 3 && k < 200) begin
          @(negedge clk);
          k++;
        end
        chk(32'(read_cnt >= 3), 32'd1, "flush sequence reached word 2");
        ic_flush = 1'b1;
        @(negedge clk);
        ic_flush = 1'b0;
      end
    join
    do_read(32'h0000_3028, 32'hD0, 32'hD2, 4, 1'b0, "re-read after flush 3028");
    do_read(32'h0000_2014, 32'hC0, 32'hC1, 4, 1'b0, "flushed line 2014");
    do_read(32'h0000_2018, 32'hC0, 32'hC2, 0, 1'b0, "hit after refill 2018");
    mem_lat = 1;

    // rdy=0 for 5 cycles while waiting on word 0
    mem_en = 1'b0;
    fork
      do_read(32'h0000_4030, 32'hE0, 32'hE0, 4, 1'b0, "freeze 4030");
      begin
        int k = 0;
        while (!mem_read && k < 50) begin
          @(negedge clk);
          k++;
        end
        chk(32'(mem_read), 32'd1, "freeze mem_read before stall");
        rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk(32'(mem_read), 32'd1, $sformatf("freeze mem_read cycle %0d", c));
          chk(mem_addr, 32'h0000_4030, $sformatf("freeze mem_addr cycle %0d", c));
          chk(32'(ic_done), 32'd0, $sformatf("freeze ic_done cycle %0d", c));
        end
        rdy = 1'b1;
        mem_en = 1'b1;
      end
    join
    do_read(32'h0000_4034, 32'hE0, 32'hE1, 0, 1'b0, "hit 4034");

    // Reset in the middle of a refill
    mem_en = 1'b0;
    begin
      int k = 0;
      @(negedge clk);
      ic_addr = 32'h0000_5040;
      ic_read = 1'b1;
      while (!mem_read && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk(32'(mem_read), 32'd1, "reset test refill started");
      #2;
      rst = 1'b0;
      #1;
      chk(32'(mem_read), 32'd0, "async reset mem_read");
      chk(32'(ic_done), 32'd0, "async reset ic_done");
      chk(mem_addr, 32'h0, "async reset mem_addr");
      ic_read = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      mem_en = 1'b1;
    end
    do_read(32'h0000_4034, 32'hE0, 32'hE1, 4, 1'b0, "miss after reset 4034");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
